upload_packer: RTL

Downstream framing stage for the I2C slave handler's CDC upload bus. It buffers the payload bytes of one upload burst, counts them and accumulates a checksum. When the burst ends, it emits a single framed packet on a byte-wide valid/ready stream that feeds the USB CDC transmit path: header, source, length, payload, then an optional checksum. Only one packet is in flight at a time; while a frame is being transmitted, the upload side is back-pressured.

---
 rtl/upload_pkg.sv | 21 ++
 rtl/upload_fifo.sv | 59 +++++
 rtl/upload_packer.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/upload_pkg.sv
// Shared definitions for the upload packer: header defaults, the
// length-field width and the framing state type.
package upload_pkg;

  localparam logic [7:0] HDR0_DEFAULT = 8'hAA;
  localparam logic [7:0] HDR1_DEFAULT = 8'h44;
  localparam int unsigned LEN_W = 16;

  typedef enum logic [3:0] {
    S_IDLE,
    S_COLLECT,
    S_HDR0,
    S_HDR1,
    S_SRC,
    S_LEN_H,
    S_LEN_L,
    S_PAYLOAD,
    S_CSUM
  } state_e;

endpackage

// File: rtl/upload_fifo.sv
// Synchronous show-ahead byte FIFO. dout always shows the oldest entry
// while the FIFO is non-empty; pop discards it. Pushing while full and
// popping while empty are ignored.
module upload_fifo #(
  parameter int unsigned DEPTH = 64
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  logic       pop,
  input  logic [7:0] din,
  output logic [7:0] dout,
  output logic       full,
  output logic       empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [7:0]  mem_q [DEPTH];
  logic [AW:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0] rd_ptr_q, rd_ptr_d;
  logic        do_push, do_pop;

  // Pointers carry one extra wrap bit so full and empty can be told apart.
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                 (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign dout  = mem_q[rd_ptr_q[AW-1:0]];

  // Next-pointer computation with guarded push/pop.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    do_push  = push && !full;
    do_pop   = pop && !empty;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
  end

  // Pointer registers; reset empties the FIFO.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage write port.
  always_ff @(posedge clk) begin
    // NOTE: the storage array is not reset; the pointers alone define which entries are valid.
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= din;
  end

endmodule

// File: rtl/upload_packer.sv
// Upload packer: buffers one upload burst and emits it as a framed packet
// HDR0 HDR1 SRC LEN_H LEN_L PAYLOAD... [CSUM] on a valid/ready byte stream.
// Optional feature: define UPLOAD_PACKER_CHECKSUM_EN to append the
// modulo-256 checksum byte to every frame.
module upload_packer
  import upload_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 64,
  parameter logic [7:0]  HDR0       = HDR0_DEFAULT,
  parameter logic [7:0]  HDR1       = HDR1_DEFAULT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       upload_active,
  input  logic       upload_req,
  input  logic [7:0] upload_data,
  input  logic [7:0] upload_source,
  input  logic       upload_valid,
  output logic       upload_ready,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  input  logic       tx_ready,
  output logic       busy
);

  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);

  state_e             state_q, state_d;
  logic [7:0]         src_q, src_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               tx_valid_q, tx_valid_d;
  logic [7:0]         tx_data_q, tx_data_d;
  logic               busy_q, busy_d;
`ifdef UPLOAD_PACKER_CHECKSUM_EN
  logic [7:0]         csum_q, csum_d;
`endif

  logic               push, pop, accept, tx_hs;
  logic               fifo_full, fifo_empty;
  logic [7:0]         fifo_dout;
  logic [LEN_W-1:0]   len;
  logic               unused_req;

  // upload_req is informational only; acceptance is valid && ready.
  assign unused_req = upload_req;

  upload_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .din   (upload_data),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign upload_ready = ((state_q == S_IDLE) || (state_q == S_COLLECT)) && !fifo_full;
  assign accept       = upload_valid && upload_ready;
  assign tx_hs        = tx_valid_q && tx_ready;
  assign len          = LEN_W'(count_q);
  assign tx_valid     = tx_valid_q;
  assign tx_data      = tx_data_q;
  assign busy         = busy_q;

  // Framing FSM next-state: the byte to present next is loaded into the
  // output register on the handshake of the current one, so no bubbles occur.
  always_comb begin
    state_d    = state_q;
    src_d      = src_q;
    count_d    = count_q;
    tx_valid_d = tx_valid_q;
    tx_data_d  = tx_data_q;
    push       = 1'b0;
    pop        = 1'b0;
`ifdef UPLOAD_PACKER_CHECKSUM_EN
    csum_d     = csum_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          src_d   = upload_source;
          push    = 1'b1;
          count_d = CNT_W'(1);
`ifdef UPLOAD_PACKER_CHECKSUM_EN
          csum_d  = upload_source + upload_data;
`endif
          state_d = S_COLLECT;
        end
      end
      S_COLLECT: begin
        if (accept) begin
          push    = 1'b1;
          count_d = count_q + 1'b1;
`ifdef UPLOAD_PACKER_CHECKSUM_EN
          csum_d  = csum_q + upload_data;
`endif
        end
        if (!upload_active) begin
          state_d    = S_HDR0;
          tx_valid_d = 1'b1;
          tx_data_d  = HDR0;
        end
      end
      S_HDR0: if (tx_hs) begin
        state_d   = S_HDR1;
        tx_data_d = HDR1;
      end
      S_HDR1: if (tx_hs) begin
        state_d   = S_SRC;
        tx_data_d = src_q;
      end
      S_SRC: if (tx_hs) begin
        state_d   = S_LEN_H;
        tx_data_d = len[LEN_W-1:8];
      end
      S_LEN_H: if (tx_hs) begin
        state_d   = S_LEN_L;
        tx_data_d = len[7:0];
      end
      S_LEN_L: if (tx_hs) begin
        // Move the FIFO head straight into the output register.
        state_d   = S_PAYLOAD;
        tx_data_d = fifo_dout;
        pop       = 1'b1;
      end
      S_PAYLOAD: if (tx_hs) begin
        if (!fifo_empty) begin
          tx_data_d = fifo_dout;
          pop       = 1'b1;
        end else begin
`ifdef UPLOAD_PACKER_CHECKSUM_EN
          state_d   = S_CSUM;
          tx_data_d = csum_q + len[LEN_W-1:8] + len[7:0];
`else
          state_d    = S_IDLE;
          tx_valid_d = 1'b0;
          tx_data_d  = '0;
          count_d    = '0;
`endif
        end
      end
`ifdef UPLOAD_PACKER_CHECKSUM_EN
      S_CSUM: if (tx_hs) begin
        state_d    = S_IDLE;
        tx_valid_d = 1'b0;
        tx_data_d  = '0;
        count_d    = '0;
        csum_d     = '0;
      end
`endif
      default: begin
        state_d    = S_IDLE;
        tx_valid_d = 1'b0;
        tx_data_d  = '0;
        count_d    = '0;
      end
    endcase
    busy_d = (state_d != S_IDLE);
  end

  // State and registered outputs; reset abandons any partial frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      src_q      <= '0;
      count_q    <= '0;
      tx_valid_q <= 1'b0;
      tx_data_q  <= '0;
      busy_q     <= 1'b0;
`ifdef UPLOAD_PACKER_CHECKSUM_EN
      csum_q     <= '0;
`endif
    end else begin
      state_q    <= state_d;
      src_q      <= src_d;
      count_q    <= count_d;
      tx_valid_q <= tx_valid_d;
      tx_data_q  <= tx_data_d;
      busy_q     <= busy_d;
`ifdef UPLOAD_PACKER_CHECKSUM_EN
      csum_q     <= csum_d;
`endif
    end
  end

endmodule
